imem_byte_responder: RTL and testbench
======================================

Name: imem_byte_responder

Overview:
Byte-organised instruction memory that answers the instruction buffer's two-byte fetch interface. Each cycle it accepts two byte addresses (addr_low, addr_high) and returns the addressed bytes (ins_low, ins_high) one cycle later. A word-oriented program-load port with a valid/ready handshake and a small FSM fills the array. It sits between the fetch buffer and the program loader (testbench or boot source).

Parameters:
DEPTH_BYTES, 512, number of bytes in the array; must be a power of two and at least 8.
ADDR_W, 9, log2(DEPTH_BYTES); the number of address bits used.
LEN_W, 16, width of the load word-count field.

Ports:
clk  in  1  single clock; all logic on posedge.
rst  in  1  synchronous, active-high reset.
addr_low  in  32  byte address for the low byte of the fetch pair.
addr_high  in  32  byte address for the high byte of the fetch pair.
ins_low  out  8  registered byte read from addr_low.
ins_high  out  8  registered byte read from addr_high.
load_start  in  1  starts a load; accepted only in IDLE.
load_base  in  32  byte base address of the load; sampled on an accepted start.
load_len  in  LEN_W  number of 32-bit words to load; sampled on an accepted start.
load_data  in  32  word to write, little-endian.
load_valid  in  1  load_data is valid.
load_ready  out  1  block accepts a word this cycle.
loading  out  1  high in the LOAD state.
load_done  out  1  one-cycle pulse when a load completes.

Behaviour:
- Reset values: ins_low=0, ins_high=0, load_ready=0, loading=0, load_done=0, FSM=IDLE, word counter=0, write pointer=0.
- Reset does not clear the array. At power-up (initial block) the array holds NOP: byte i = NOP_WORD byte (i mod 4). NOP_WORD = 32'h00000013, so the byte pattern is 13,00,00,00.
- Read path:
  - Both ports are independent, always active, and have 1-cycle latency: ins_low <= mem[addr_low[ADDR_W-1:0]].
  - The same rule applies to ins_high with addr_high.
  - Upper address bits are ignored, so addresses wrap modulo DEPTH_BYTES.
  - Both ports may address the same byte.
- Read/write collision: if a read hits a byte written in the same cycle, the read returns the old byte (read-before-write). The new byte is visible from the next read.
- FSM states: IDLE, LOAD, DONE.
  - IDLE: on load_start, set ptr = {load_base[ADDR_W-1:2], 2'b00} (word-aligned; base[1:0] ignored), len = load_len, cnt = 0.
    - If load_len == 0, go to DONE.
    - Otherwise go to LOAD.
  - LOAD: load_ready=1 and loading=1.
    - On load_valid && load_ready, write mem[ptr+0..3] = load_data[7:0], [15:8], [23:16], [31:24].
    - Then ptr += 4 (mod DEPTH_BYTES) and cnt += 1.
    - If cnt+1 == len, go to DONE.
    - If load_valid is low, hold the state; there is no timeout.
  - DONE: load_done=1 for exactly one cycle, load_ready=0, then go to IDLE.
- load_start outside IDLE is ignored. load_base and load_len are only sampled on an accepted start.
- load_ready is a registered state decode and does not depend combinationally on load_valid.
- A load longer than DEPTH_BYTES/4 words wraps and overwrites earlier words; no error is flagged.
- Reset mid-load:
  - Next cycle the FSM is IDLE, load_ready=0, loading=0.
  - No load_done is produced.
  - Bytes already written are retained.
- Reads are served in every state; fetch is never stalled by loading.

Decomposition:
- Shared package scpu_imem_pkg:
  - NOP_WORD constant (32'h00000013).
  - FSM state enum: IDLE=2'd0, LOAD=2'd1, DONE=2'd2.
  - Default DEPTH_BYTES/ADDR_W constants.
- Sub-module imem_byte_array (DEPTH_BYTES-byte storage):
  - Two registered byte read ports.
  - One 4-byte word write port with enable.
  - Owns the NOP initialisation.
- The top level holds the load FSM, pointer and counter.

Test Plan:
1. After reset, drive addr_low=0, addr_high=1 -> next cycle ins_low=8'h13, ins_high=8'h00. Then addr_low=4, addr_high=7 -> 8'h13, 8'h00.
2. load_start with base=0x10, len=2; feed 32'hDEADBEEF then 32'h00500093 back-to-back. Expect:
   - load_ready=1 for 2 cycles, then load_done pulses once.
   - Read 0x10/0x11 -> EF/BE, 0x12/0x13 -> AD/DE, 0x14/0x15 -> 93/00.
3. Same load with load_valid low for 3 cycles between words -> nothing is written while valid is low, the final contents match scenario 2, and load_done is still a single pulse.
4. base=0x13, len=0 -> load_done goes high 1 cycle after start, load_ready never asserts, and the byte at 0x10 stays unchanged. A load_start during DONE or LOAD is ignored.
5. Wrap: base=DEPTH_BYTES-4, len=2, words 32'h11223344 and 32'h55667788 -> byte DEPTH-4 = 44, byte 0 = 88, byte 3 = 55.
6. rst asserted after 1 of 3 words is accepted -> next cycle loading=0 and load_ready=0, no load_done, and the first word is still readable. A same-cycle read of a byte being written returns the old value.

Source files
------------

// File: rtl/scpu_imem_pkg.sv
// scpu_imem_pkg: shared constants and load FSM state encoding for the byte instruction memory
package scpu_imem_pkg;
    localparam logic [31:0] NOP_WORD = 32'h00000013;
    localparam int DEF_DEPTH_BYTES = 512;
    localparam int DEF_ADDR_W = 9;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } imem_state_t;
endpackage

// File: rtl/imem_byte_array.sv
// imem_byte_array: byte storage with two registered read ports and one word write port
module imem_byte_array
    import scpu_imem_pkg::*;
#(
    parameter int DEPTH_BYTES = DEF_DEPTH_BYTES,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [7:0]        rd_data_a,
    output logic [7:0]        rd_data_b,
    input  logic              wr_en,
    input  logic [ADDR_W-3:0] wr_word,
    input  logic [31:0]       wr_data
);
    logic [7:0] mem [DEPTH_BYTES];
    // Power-up contents are a sled of NOPs; reset never touches the array.
    initial for (int i = 0; i < DEPTH_BYTES; i++) mem[i] = NOP_WORD[8*(i%4) +: 8];
    always_ff @(posedge clk)
        if (wr_en)
            for (int k = 0; k < 4; k++) mem[{wr_word, 2'(k)}] <= wr_data[8*k +: 8];
    // Non-blocking update gives read-before-write on a same-cycle collision.
    always_ff @(posedge clk) begin
        rd_data_a <= rst ? 8'h00 : mem[rd_addr_a];
        rd_data_b <= rst ? 8'h00 : mem[rd_addr_b];
    end
endmodule

// File: rtl/imem_byte_responder.sv
// imem_byte_responder: two-byte fetch memory with a word-oriented valid/ready program loader
module imem_byte_responder
    import scpu_imem_pkg::*;
#(
    parameter int DEPTH_BYTES = DEF_DEPTH_BYTES,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      addr_low,
    input  logic [31:0]      addr_high,
    output logic [7:0]       ins_low,
    output logic [7:0]       ins_high,
    input  logic             load_start,
    input  logic [31:0]      load_base,
    input  logic [LEN_W-1:0] load_len,
    input  logic [31:0]      load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             loading,
    output logic             load_done
);
    imem_state_t       state, state_n;
    logic [ADDR_W-3:0] ptr;
    logic [LEN_W-1:0]  len, cnt;
    logic              start, accept, last;
    logic              unused;
    assign unused = ^{addr_low[31:ADDR_W], addr_high[31:ADDR_W], load_base[31:ADDR_W], load_base[1:0]};
    always_comb begin
        start = (state == IDLE) && load_start;
        accept = (state == LOAD) && load_valid;
        last = (cnt + LEN_W'(1)) == len;
        state_n = start ? (load_len == '0 ? DONE : LOAD) :
                  (accept && last) ? DONE :
                  (state == DONE) ? IDLE : state;
        load_ready = state == LOAD;
        loading = state == LOAD;
        load_done = state == DONE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr <= '0;
            len <= '0;
            cnt <= '0;
        end else begin
            state <= state_n;
            ptr <= start ? load_base[ADDR_W-1:2] : accept ? ptr + 1'b1 : ptr;
            len <= start ? load_len : len;
            cnt <= start ? '0 : accept ? cnt + 1'b1 : cnt;
        end
    end
    imem_byte_array #(.DEPTH_BYTES(DEPTH_BYTES), .ADDR_W(ADDR_W)) u_array (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_a (addr_low[ADDR_W-1:0]),
        .rd_addr_b (addr_high[ADDR_W-1:0]),
        .rd_data_a (ins_low),
        .rd_data_b (ins_high),
        .wr_en     (accept && !rst),
        .wr_word   (ptr),
        .wr_data   (load_data)
    );
endmodule

// File: tb/tb_imem_byte_responder.sv
// tb_imem_byte_responder: directed self-checking bench for the byte instruction memory
module tb_imem_byte_responder;
    logic        clk = 0;
    logic        rst = 1;
    logic [31:0] addr_low = 0, addr_high = 0;
    logic [7:0]  ins_low, ins_high;
    logic        load_start = 0;
    logic [31:0] load_base = 0;
    logic [15:0] load_len = 0;
    logic [31:0] load_data = 0;
    logic        load_valid = 0;
    logic        load_ready, loading, load_done;
    int checks = 0;
    int failures = 0;

    imem_byte_responder dut (
        .clk(clk), .rst(rst), .addr_low(addr_low), .addr_high(addr_high),
        .ins_low(ins_low), .ins_high(ins_high), .load_start(load_start),
        .load_base(load_base), .load_len(load_len), .load_data(load_data),
        .load_valid(load_valid), .load_ready(load_ready), .loading(loading),
        .load_done(load_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] b);
        addr_low = a;
        addr_high = b;
        tick();
    endtask

    task automatic test_reset();
        rst = 1;
        tick();
        tick();
        checks++; if (ins_low !== 8'h00) begin failures++; $display("FAIL reset_ins_low got=%h exp=00", ins_low); end
        checks++; if (ins_high !== 8'h00) begin failures++; $display("FAIL reset_ins_high got=%h exp=00", ins_high); end
        checks++; if ({load_ready, loading, load_done} !== 3'b000) begin failures++; $display("FAIL reset_ctrl got=%b exp=000", {load_ready, loading, load_done}); end
        rst = 0;
    endtask

    task automatic test_nop_read();
        rd(0, 1);
        checks++; if ({ins_low, ins_high} !== 16'h1300) begin failures++; $display("FAIL nop_0_1 got=%h exp=1300", {ins_low, ins_high}); end
        rd(4, 7);
        checks++; if ({ins_low, ins_high} !== 16'h1300) begin failures++; $display("FAIL nop_4_7 got=%h exp=1300", {ins_low, ins_high}); end
        rd(32'h0000_0204, 32'hFFFF_FE00);
        checks++; if ({ins_low, ins_high} !== 16'h1313) begin failures++; $display("FAIL nop_wrap got=%h exp=1313", {ins_low, ins_high}); end
    endtask

    task automatic test_load_b2b();
        load_start = 1; load_base = 32'h10; load_len = 2;
        tick();
        load_start = 0;
        checks++; if ({load_ready, loading} !== 2'b11) begin failures++; $display("FAIL b2b_ready0 got=%b exp=11", {load_ready, loading}); end
        load_valid = 1; load_data = 32'hDEADBEEF;
        tick();
        checks++; if (load_ready !== 1'b1 || load_done !== 1'b0) begin failures++; $display("FAIL b2b_ready1 got=%b%b exp=10", load_ready, load_done); end
        load_data = 32'h00500093;
        tick();
        load_valid = 0;
        checks++; if ({load_done, load_ready, loading} !== 3'b100) begin failures++; $display("FAIL b2b_done got=%b exp=100", {load_done, load_ready, loading}); end
        tick();
        checks++; if ({load_done, load_ready, loading} !== 3'b000) begin failures++; $display("FAIL b2b_idle got=%b exp=000", {load_done, load_ready, loading}); end
        rd(32'h10, 32'h11);
        checks++; if ({ins_low, ins_high} !== 16'hEFBE) begin failures++; $display("FAIL b2b_10 got=%h exp=efbe", {ins_low, ins_high}); end
        rd(32'h12, 32'h13);
        checks++; if ({ins_low, ins_high} !== 16'hADDE) begin failures++; $display("FAIL b2b_12 got=%h exp=adde", {ins_low, ins_high}); end
        rd(32'h14, 32'h15);
        checks++; if ({ins_low, ins_high} !== 16'h9300) begin failures++; $display("FAIL b2b_14 got=%h exp=9300", {ins_low, ins_high}); end
    endtask

    task automatic test_load_gaps();
        int dones = 0;
        load_start = 1; load_base = 32'h20; load_len = 2;
        tick();
        load_start = 0;
        load_valid = 1; load_data = 32'hDEADBEEF;
        tick();
        load_valid = 0; load_data = 32'h00500093;
        addr_low = 32'h24; addr_high = 32'h25;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({load_ready, load_done} !== 2'b10) begin failures++; $display("FAIL gap_hold%0d got=%b exp=10", i, {load_ready, load_done}); end
            checks++; if ({ins_low, ins_high} !== 16'h1300) begin failures++; $display("FAIL gap_nowrite%0d got=%h exp=1300", i, {ins_low, ins_high}); end
        end
        load_valid = 1;
        tick();
        load_valid = 0;
        for (int i = 0; i < 5; i++) begin
            if (load_done === 1'b1) dones++;
            tick();
        end
        checks++; if (dones != 1) begin failures++; $display("FAIL gap_done_pulses got=%0d exp=1", dones); end
        rd(32'h20, 32'h23);
        checks++; if ({ins_low, ins_high} !== 16'hEFDE) begin failures++; $display("FAIL gap_20 got=%h exp=efde", {ins_low, ins_high}); end
        rd(32'h24, 32'h25);
        checks++; if ({ins_low, ins_high} !== 16'h9300) begin failures++; $display("FAIL gap_24 got=%h exp=9300", {ins_low, ins_high}); end
    endtask

    task automatic test_zero_len();
        load_start = 1; load_base = 32'h13; load_len = 0;
        tick();
        checks++; if ({load_done, load_ready} !== 2'b10) begin failures++; $display("FAIL zl_done got=%b exp=10", {load_done, load_ready}); end
        load_base = 32'h40; load_len = 1;
        tick();
        load_start = 0;
        checks++; if ({load_done, loading} !== 2'b00) begin failures++; $display("FAIL zl_ign_done got=%b exp=00", {load_done, loading}); end
        tick();
        checks++; if (loading !== 1'b0) begin failures++; $display("FAIL zl_still_idle got=%b exp=0", loading); end
        rd(32'h10, 32'h13);
        checks++; if ({ins_low, ins_high} !== 16'hEFDE) begin failures++; $display("FAIL zl_keep got=%h exp=efde", {ins_low, ins_high}); end
        load_start = 1; load_base = 32'h30; load_len = 1;
        tick();
        load_base = 32'h40; load_len = 3;
        load_valid = 1; load_data = 32'hCAFEF00D;
        tick();
        load_start = 0; load_valid = 0;
        checks++; if (load_done !== 1'b1) begin failures++; $display("FAIL ign_load_done got=%b exp=1", load_done); end
        tick();
        rd(32'h30, 32'h33);
        checks++; if ({ins_low, ins_high} !== 16'h0DCA) begin failures++; $display("FAIL ign_load_30 got=%h exp=0dca", {ins_low, ins_high}); end
        rd(32'h40, 32'h41);
        checks++; if ({ins_low, ins_high} !== 16'h1300) begin failures++; $display("FAIL ign_load_40 got=%h exp=1300", {ins_low, ins_high}); end
    endtask

    task automatic test_wrap();
        load_start = 1; load_base = 32'd508; load_len = 2;
        tick();
        load_start = 0;
        load_valid = 1; load_data = 32'h11223344;
        tick();
        load_data = 32'h55667788;
        tick();
        load_valid = 0;
        tick();
        rd(32'd508, 32'd0);
        checks++; if ({ins_low, ins_high} !== 16'h4488) begin failures++; $display("FAIL wrap_508_0 got=%h exp=4488", {ins_low, ins_high}); end
        rd(32'd3, 32'd511);
        checks++; if ({ins_low, ins_high} !== 16'h5511) begin failures++; $display("FAIL wrap_3_511 got=%h exp=5511", {ins_low, ins_high}); end
    endtask

    task automatic test_reset_mid_load();
        int dones = 0;
        load_start = 1; load_base = 32'h50; load_len = 3;
        tick();
        load_start = 0;
        load_valid = 1; load_data = 32'hA1B2C3D4;
        tick();
        load_valid = 0; rst = 1;
        tick();
        rst = 0;
        checks++; if ({loading, load_ready, load_done} !== 3'b000) begin failures++; $display("FAIL rml_idle got=%b exp=000", {loading, load_ready, load_done}); end
        for (int i = 0; i < 4; i++) begin
            if (load_done === 1'b1) dones++;
            tick();
        end
        checks++; if (dones != 0) begin failures++; $display("FAIL rml_no_done got=%0d exp=0", dones); end
        rd(32'h50, 32'h53);
        checks++; if ({ins_low, ins_high} !== 16'hD4A1) begin failures++; $display("FAIL rml_kept got=%h exp=d4a1", {ins_low, ins_high}); end
        rd(32'h54, 32'h55);
        checks++; if ({ins_low, ins_high} !== 16'h1300) begin failures++; $display("FAIL rml_unwritten got=%h exp=1300", {ins_low, ins_high}); end
        load_start = 1; load_base = 32'h60; load_len = 1;
        tick();
        load_start = 0;
        load_valid = 1; load_data = 32'h99887766;
        addr_low = 32'h60; addr_high = 32'h63;
        tick();
        load_valid = 0;
        checks++; if ({ins_low, ins_high} !== 16'h1300) begin failures++; $display("FAIL rbw_old got=%h exp=1300", {ins_low, ins_high}); end
        rd(32'h60, 32'h63);
        checks++; if ({ins_low, ins_high} !== 16'h6699) begin failures++; $display("FAIL rbw_new got=%h exp=6699", {ins_low, ins_high}); end
    endtask

    initial begin
        test_reset();
        test_nop_read();
        test_load_b2b();
        test_load_gaps();
        test_zero_len();
        test_wrap();
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
